// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Optional macro PS2_HOST_TX_RETRY_EN: retry a failed command once before pulsing error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES    = 6000,
  parameter int START_HOLD_CYCLES = 250,
  parameter int TIMEOUT_CYCLES    = 750000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = (INHIBIT_CYCLES > 1)    ? $clog2(INHIBIT_CYCLES)    : 1;
  localparam int SW = (START_HOLD_CYCLES > 1) ? $clog2(START_HOLD_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1)    ? $clog2(TIMEOUT_CYCLES)    : 1;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE, FAIL
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [7:0]    cmd_byte;
  logic          parity;
  logic [IW-1:0] inh_cnt;
  logic [SW-1:0] st_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    bit_cnt;
  logic          data_low;
  logic          clk_s, data_s, fall, tmo_hit;
`ifdef PS2_HOST_TX_RETRY_EN
  logic          retried;
`endif

  // clk_sync[2] is the previous synced sample, used only for edge detection
  assign clk_s   = clk_sync[1];
  assign data_s  = data_sync[1];
  assign fall    = clk_sync[2] & ~clk_sync[1];
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    case (state)
      IDLE:      if (cmd_valid) state_nxt = INHIBIT;
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) state_nxt = START;
      end
      START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (st_cnt == SW'(START_HOLD_CYCLES - 1)) state_nxt = SEND;
      end
      SEND: begin
        ps2_data_oe = data_low;
        if (tmo_hit)                           state_nxt = FAIL;
        else if (fall && bit_cnt == 4'd9)      state_nxt = ACK;
      end
      ACK: begin
        if (tmo_hit)   state_nxt = FAIL;
        else if (fall) state_nxt = data_s ? FAIL : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        // a completed handshake wins over a timeout landing on the same cycle
        if (clk_s && data_s) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          state_nxt = FAIL;
        end
      end
      FAIL: begin
`ifdef PS2_HOST_TX_RETRY_EN
        if (!retried) begin
          state_nxt = INHIBIT;
        end else begin
          error     = 1'b1;
          state_nxt = IDLE;
        end
`else
        error     = 1'b1;
        state_nxt = IDLE;
`endif
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cmd_byte <= '0;
      parity   <= 1'b0;
      inh_cnt  <= '0;
      st_cnt   <= '0;
      tmo_cnt  <= '0;
      bit_cnt  <= '0;
      data_low <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        cmd_byte <= cmd_data;
        parity   <= ~^cmd_data;
      end
      inh_cnt <= (state == INHIBIT && state_nxt == INHIBIT) ? inh_cnt + 1'b1 : '0;
      st_cnt  <= (state == START && state_nxt == START)     ? st_cnt + 1'b1  : '0;
      // zero outside the transfer window, so it is clear on SEND entry
      if (state == SEND || state == ACK || state == WAIT_IDLE) begin
        if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (state == SEND) begin
        if (fall) bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end
      if (state == START) begin
        data_low <= 1'b1;
      end else if (state == SEND) begin
        if (fall) begin
          if (bit_cnt < 4'd8)       data_low <= ~cmd_byte[bit_cnt[2:0]];
          else if (bit_cnt == 4'd8) data_low <= ~parity;
          else                      data_low <= 1'b0;
        end
      end else begin
        data_low <= 1'b0;
      end
    end
  end

`ifdef PS2_HOST_TX_RETRY_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)              retried <= 1'b0;
    else if (state == FAIL)   retried <= 1'b1;
    else if (state == IDLE)   retried <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH = 100;
  localparam int STH = 10;
  localparam int TMO = 20000;
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_HOLD_CYCLES(STH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .resetn(resetn), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0, inh_starts = 0, err_cyc = 0;
  logic busy_at_pulse = 1'b0, busy_after = 1'b0, ready_after = 1'b0;
  logic pulse_d = 1'b0, done_d = 1'b0, err_d = 1'b0, clk_oe_d = 1'b0;
  logic [1:0] err_oe = '0;

  // pulse bookkeeping, so pulses are seen even while the device model is busy
  always @(negedge clock) begin
    cyc      <= cyc + 1;
    done_d   <= done;
    err_d    <= error;
    pulse_d  <= done | error;
    clk_oe_d <= ps2_clk_oe;
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc + 1;
      err_oe  <= {ps2_clk_oe, ps2_data_oe};
    end
    if (done | error) busy_at_pulse <= busy;
    if (done && error) both_cnt <= both_cnt + 1;
    if ((done && done_d) || (error && err_d)) wide_cnt <= wide_cnt + 1;
    if (pulse_d) begin
      busy_after  <= busy;
      ready_after <= cmd_ready;
    end
    if (ps2_clk_oe && !clk_oe_d) inh_starts <= inh_starts + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // accept a command and time the INHIBIT and START phases
  task automatic run_cmd(input logic [7:0] b, input bit poke, output int t_send);
    int inh, st;
    cmd_data  = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < 1000) begin
      if (poke && inh == 10) begin
        cmd_valid = 1'b1;
        cmd_data  = 8'hAA;
      end else begin
        cmd_valid = 1'b0;
      end
      inh++;
      tick();
    end
    cmd_valid = 1'b0;
    check("inhibit_len", inh, INH);
    st = 0;
    while (ps2_clk_oe && ps2_data_oe && st < 1000) begin
      st++;
      tick();
    end
    check("start_len", st, STH);
    t_send = cyc;
  endtask

  // device clocks 10 bits (sampling on rising edge), then an 11th clock for ACK
  task automatic dev_xfer(input bit ack, input int abort_fall, output logic [9:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (!(!ps2_clk_oe && ps2_data_oe) && w < 2000) begin
      w++;
      tick();
    end
    check("wait_send", (w < 2000), 1);
    repeat (10) tick();
    for (int i = 0; i < 11; i++) begin
      if (i == 10) begin
        dev_data_low = ack;
        repeat (5) tick();
      end
      dev_clk_low = 1'b1;
      if (i + 1 == abort_fall) begin
        repeat (6) tick();
        check("abort_pre_data_oe", ps2_data_oe, 1);
        #2 resetn = 1'b0;
        #1;
        check("abort_clk_oe", ps2_clk_oe, 0);
        check("abort_data_oe", ps2_data_oe, 0);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        return;
      end
      repeat (20) tick();
      dev_clk_low = 1'b0;
      if (i < 10) bits[i] = ps2_data_in;
      if (i == 10) begin
        repeat (5) tick();
        dev_data_low = 1'b0;
      end
      repeat (20) tick();
    end
  endtask

  task automatic wait_pulse(input int d0, input int e0);
    int w;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 600) begin
      w++;
      tick();
    end
    check("pulse_seen", (w < 600), 1);
    repeat (2) tick();
  endtask

  logic [7:0]  vec_byte [4] = '{8'hED, 8'hFF, 8'h00, 8'h01};
  logic        vec_par  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [9:0] bits;
    int t0, d0, e0, i0;

    repeat (3) tick();
    check("rst_ready", cmd_ready, 1);
    check("rst_outs", {busy, ps2_clk_oe, ps2_data_oe, done, error}, 0);
    resetn = 1'b1;
    repeat (2) tick();
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_outs", {busy, ps2_clk_oe, ps2_data_oe, done, error}, 0);

    // normal transfers with ACK
    e0 = err_cnt;
    for (int k = 0; k < 4; k++) begin
      d0 = done_cnt;
      run_cmd(vec_byte[k], 1'b0, t0);
      dev_xfer(1'b1, 0, bits);
      check($sformatf("data_%0h", vec_byte[k]), bits[7:0], vec_byte[k]);
      check($sformatf("parity_%0h", vec_byte[k]), bits[8], vec_par[k]);
      check($sformatf("stop_%0h", vec_byte[k]), bits[9], 1);
      wait_pulse(d0, e0);
      check("done_once", done_cnt - d0, 1);
      check("busy_at_done", busy_at_pulse, 1);
      check("busy_after_done", busy_after, 0);
      check("ready_after_done", ready_after, 1);
    end
    check("no_error_on_ack", err_cnt - e0, 0);

    // missing ACK
    d0 = done_cnt; e0 = err_cnt; i0 = inh_starts;
    run_cmd(8'h5A, 1'b0, t0);
    dev_xfer(1'b0, 0, bits);
    if (RETRY != 0) dev_xfer(1'b0, 0, bits);
    wait_pulse(d0, e0);
    check("noack_error", err_cnt - e0, 1);
    check("noack_done", done_cnt - d0, 0);
    check("noack_oe", err_oe, 0);
    check("noack_ready", ready_after, 1);
    check("noack_attempts", inh_starts - i0, RETRY + 1);

    // device never clocks
    d0 = done_cnt; e0 = err_cnt;
    run_cmd(8'hFF, 1'b0, t0);
    for (int w = 0; w < 45000 && err_cnt == e0; w++) tick();
    repeat (2) tick();
    check("tmo_error", err_cnt - e0, 1);
    check("tmo_latency", err_cyc - t0, (RETRY != 0) ? (2 * TMO + 1 + INH + STH) : TMO);
    check("tmo_no_done", done_cnt - d0, 0);

    // reset in the middle of the data bits
    d0 = done_cnt;
    run_cmd(8'h00, 1'b0, t0);
    dev_xfer(1'b1, 5, bits);
    repeat (3) tick();
    check("midrst_ready", cmd_ready, 1);
    resetn = 1'b1;
    repeat (3) tick();
    check("rel_ready_busy", {cmd_ready, busy}, 2'b10);
    run_cmd(8'hF4, 1'b0, t0);
    dev_xfer(1'b1, 0, bits);
    check("data_f4", bits[7:0], 8'hF4);
    check("parity_f4", bits[8], 0);
    wait_pulse(d0, err_cnt);
    check("f4_done", done_cnt - d0, 1);

    // cmd_valid while busy is dropped
    d0 = done_cnt;
    run_cmd(8'h3C, 1'b1, t0);
    dev_xfer(1'b1, 0, bits);
    check("poke_data", bits[7:0], 8'h3C);
    check("poke_parity", bits[8], 1);
    wait_pulse(d0, err_cnt);
    repeat (300) tick();
    check("poke_one_done", done_cnt - d0, 1);
    check("poke_idle", {cmd_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);

    check("done_error_overlap", both_cnt, 0);
    check("pulse_width", wide_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 keyboard port: the opposite direction to the existing PS/2 receive path.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard using the PS/2 host-request protocol, and reports success or failure.
- Drives the shared open-drain ps2_clock/ps2_data pins through active-high pull-low enables; the top level ties these to the inouts.
- The existing receiver keeps sampling the same pins.

Parameters:
- INHIBIT_CYCLES, 6000, clock cycles the host holds ps2 clock low before the request (120 us at 50 MHz).
- START_HOLD_CYCLES, 250, cycles both lines are held low before the clock is released.
- TIMEOUT_CYCLES, 750000, maximum cycles from SEND entry until the end of WAIT_IDLE (15 ms).

Ports:
- clock  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous active-low reset.
- cmd_data  in  8  command byte to transmit.
- cmd_valid  in  1  request to send cmd_data.
- cmd_ready  out  1  high when a command can be accepted.
- ps2_clk_in  in  1  raw PS/2 clock pin level.
- ps2_data_in  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release.
- ps2_data_oe  out  1  1 = pull PS/2 data low, 0 = release.
- busy  out  1  high while any transfer is in progress.
- done  out  1  one-cycle pulse: byte sent and keyboard ACK received.
- error  out  1  one-cycle pulse: timeout or missing ACK.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low. While resetn = 0 and after release: state IDLE, cmd_ready = 1, all other outputs 0 (both lines released). Reset mid-transfer releases both lines immediately.
- Input sync: ps2_clk_in and ps2_data_in each pass through 2 flops. A falling edge ("fall") is synced clock 1 on the previous cycle and 0 on the current cycle.
- Handshake: a command is accepted on a clock edge where cmd_valid && cmd_ready. cmd_data is latched together with odd parity p = ~^cmd_data. cmd_ready = 1 only in IDLE. busy = ~cmd_ready.
- States:
  - IDLE: lines released; go to INHIBIT on accept.
  - INHIBIT: clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to START.
  - START: clk_oe = 1, data_oe = 1 for START_HOLD_CYCLES cycles, then go to SEND.
  - SEND: clk_oe = 0. data_oe = 1 on entry (start bit = 0). Fall counter n starts at 0 and increments per fall:
    - falls 1..8: data_oe <= ~byte[n-1], LSB first;
    - fall 9: data_oe <= ~p;
    - fall 10: data_oe <= 0 (stop bit = 1), go to ACK.
  - ACK: on the next fall, if synced data = 0 go to WAIT_IDLE; if data = 1 go to FAIL (no ACK).
  - WAIT_IDLE: when synced clock = 1 and synced data = 1, pulse done for one cycle and go to IDLE.
  - FAIL: lines released, error pulses for one cycle, go to IDLE.
- data_oe updates within 1 cycle after the synced fall is detected (3 cycles after the pin edge). The device samples on its rising edge, at least 30 us later.
- Timeout counter: cleared on SEND entry; increments in SEND, ACK and WAIT_IDLE; reaching TIMEOUT_CYCLES goes to FAIL. The counter saturates and does not wrap.
- Counter widths are sized with $clog2 of each parameter. Counts use exact equality to the terminal value.
- Pin activity during IDLE (keyboard-originated traffic) is ignored. cmd_valid while busy is ignored; no queueing.
- done and error never assert on the same cycle. busy drops on the cycle after the done/error pulse.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined: the first entry to FAIL for a command does not pulse error. Instead both lines are released for one cycle and the FSM re-enters INHIBIT with the same latched byte. A second failure pulses error. The retry flag clears on return to IDLE.
- Undefined: the first failure pulses error immediately; no retry logic is present.

Test Plan:
- Bench parameters: INHIBIT_CYCLES = 100, START_HOLD_CYCLES = 10, TIMEOUT_CYCLES = 20000. The device model generates 40-cycle clock periods and ACKs.
- Send 0xED, device ACKs -> clk_oe high for 100 cycles, then clk_oe and data_oe both high for 10 cycles. Device samples bits 1,0,1,1,0,1,1,1 (LSB first), then parity 1, then stop 1. Then done = 1 for one cycle, busy = 0 one cycle later, error never asserted.
- Send 0xFF -> parity bit sampled as 1, done pulses. Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0.
- Device holds data high at the 11th fall (no ACK) -> error pulses once, both oe = 0, cmd_ready = 1. With PS2_HOST_TX_RETRY_EN: a second full INHIBIT/START sequence occurs before error.
- Device never clocks after START -> error exactly 20000 cycles after SEND entry; no done.
- Assert resetn = 0 at the 5th fall -> clk_oe = 0 and data_oe = 0 with no clock edge needed. After release: cmd_ready = 1, and a new 0xF4 command completes normally.
- Pulse cmd_valid while busy with 0xAA -> ignored; only the original byte is transmitted and exactly one done pulse occurs.
